// File: rtl/ahb_lite_master_arbiter.sv
// Shares one AHB-Lite master port between NUM_REQ requesters using SINGLE transfers with
// pipelined address/data slots. Define AHB_ARB_FIXED_PRIO_EN for fixed priority (default round-robin).
module ahb_lite_master_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*3-1:0]      req_size,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         HADDR,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [1:0]                HTRANS,
    output logic [DATA_W-1:0]         HWDATA,
    input  logic [DATA_W-1:0]         HRDATA,
    input  logic                      HREADY,
    input  logic                      HRESP,
    output logic                      busy
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    // Slot A: transfer in address phase
    logic              a_valid_q, a_valid_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic              a_write_q, a_write_d;
    logic [2:0]        a_size_q, a_size_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    logic [IdxW-1:0]   a_owner_q, a_owner_d;
    // Slot D: transfer in data phase
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic [IdxW-1:0]   d_owner_q, d_owner_d;
    // Set after error cycle 1: slot A is parked (bus IDLE) until the error completes
    logic              hold_q, hold_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic               pipe_empty, a_advance, a_free, hs, sel_bad, grant_found;
    logic [IdxW-1:0]    grant_idx;
    logic [NUM_REQ-1:0] eligible;
    logic [2:0]         sel_size;

`ifndef AHB_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0] last_q, last_d;
`endif

    always_comb begin
        pipe_empty = !a_valid_q && !d_valid_q && !hold_q;
        a_advance  = a_valid_q && !hold_q && HREADY;
        a_free     = !a_valid_q || a_advance;
        // Unsupported sizes answer immediately, so they wait for an empty pipe to keep order
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            eligible[i] = req_valid[i] && ((req_size[i*3 +: 3] <= 3'd2) || pipe_empty);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'(i);
            end
        end
`else
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            if (!grant_found && eligible[(int'(last_q) + k) % int'(NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'((int'(last_q) + k) % int'(NUM_REQ));
            end
        end
`endif
    end

    always_comb begin
        hs        = HREADY && a_free && grant_found;
        req_ready = '0;
        if (hs && !HRESET) begin
            req_ready[grant_idx] = 1'b1;
        end
        sel_size = req_size[int'(grant_idx)*3 +: 3];
        sel_bad  = sel_size > 3'd2;
    end

    always_comb begin
        a_valid_d = a_valid_q;
        a_addr_d  = a_addr_q;
        a_write_d = a_write_q;
        a_size_d  = a_size_q;
        a_wdata_d = a_wdata_q;
        a_owner_d = a_owner_q;
        if (hs && !sel_bad) begin
            a_valid_d = 1'b1;
            a_addr_d  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            a_write_d = req_write[grant_idx];
            a_size_d  = sel_size;
            a_wdata_d = req_write[grant_idx] ? req_wdata[int'(grant_idx)*DATA_W +: DATA_W] : '0;
            a_owner_d = grant_idx;
        end else if (a_advance) begin
            a_valid_d = 1'b0;
        end

        d_valid_d = d_valid_q;
        d_write_d = d_write_q;
        d_wdata_d = d_wdata_q;
        d_owner_d = d_owner_q;
        if (a_advance) begin
            d_valid_d = 1'b1;
            d_write_d = a_write_q;
            d_wdata_d = a_wdata_q;
            d_owner_d = a_owner_q;
        end else if (HREADY) begin
            d_valid_d = 1'b0;
        end

        if (HREADY) begin
            hold_d = 1'b0;
        end else begin
            hold_d = hold_q || (HRESP && d_valid_q);
        end

        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (d_valid_q && HREADY) begin
            rsp_valid_d[d_owner_q] = 1'b1;
            rsp_rdata_d = d_write_q ? '0 : HRDATA;
            rsp_err_d   = HRESP;
        end else if (hs && sel_bad) begin
            rsp_valid_d[grant_idx] = 1'b1;
            rsp_err_d = 1'b1;
        end
    end

`ifndef AHB_ARB_FIXED_PRIO_EN
    always_comb begin
        last_d = hs ? grant_idx : last_q;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            last_q <= IdxW'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_valid_q   <= 1'b0;
            a_addr_q    <= '0;
            a_write_q   <= 1'b0;
            a_size_q    <= '0;
            a_wdata_q   <= '0;
            a_owner_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            d_owner_q   <= '0;
            hold_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_addr_q    <= a_addr_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            a_owner_q   <= a_owner_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            d_owner_q   <= d_owner_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        HADDR     = a_addr_q;
        HWRITE    = a_write_q;
        HSIZE     = a_size_q;
        HBURST    = 3'b000;
        HTRANS    = (a_valid_q && !hold_q) ? TransNonseq : TransIdle;
        HWDATA    = d_wdata_q;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
        busy      = a_valid_q || d_valid_q || hold_q;
    end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Directed self-checking bench for ahb_lite_master_arbiter (2 requesters, 32-bit bus).
module tb_ahb_lite_master_arbiter;

    localparam logic [31:0] Pat = 32'h5A5A_0000;

    logic        HCLK, HRESET;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [5:0]  req_size;
    logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
    logic        rsp_err, HWRITE, HREADY, HRESP, busy;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;
    logic [31:0] dp_addr;
    int checks = 0;
    int errors = 0;

    ahb_lite_master_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .busy(busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Slave model: read data derived from the accepted address
    always @(posedge HCLK) begin
        if (HTRANS == 2'b10 && HREADY) dp_addr <= HADDR;
    end
    assign HRDATA = dp_addr ^ Pat;

    task automatic set_req(input int r, input logic v, input logic w, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] d);
        req_valid[r] = v;
        req_write[r] = w;
        req_addr[r*32 +: 32] = a;
        req_size[r*3 +: 3] = s;
        req_wdata[r*32 +: 32] = d;
    endtask

    function automatic logic [31:0] rr_addr(input int r, input int k);
        return 32'h100 + 32'(r * 256) + 32'(k * 4);
    endfunction

    task automatic test_reset();
        HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; req_valid = 2'b11;
        @(negedge HCLK); @(negedge HCLK); #1;
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b want 00", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL reset_haddr: got %h want 0", HADDR); end
        @(negedge HCLK);
        HRESET = 1'b0; req_valid = 2'b00;
    endtask

    task automatic test_rr_reads();
        int cnt [2];
        logic [1:0] exp_rdy;
        cnt[0] = 0; cnt[1] = 0;
        HREADY = 1'b1; HRESP = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge HCLK);
            for (int r = 0; r < 2; r++) set_req(r, cnt[r] < 4, 1'b0, rr_addr(r, cnt[r]), 3'd2, 32'h0);
            #1;
            if (n < 8) begin
                exp_rdy = (n % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant n=%0d: got %b want %b", n, req_ready, exp_rdy); end
                cnt[n % 2]++;
            end
            if (n >= 1 && n <= 8) begin
                checks++; if (HTRANS !== 2'b10 || HADDR !== rr_addr((n-1) % 2, (n-1) / 2)) begin
                    errors++; $display("FAIL rr_addr_phase n=%0d: got %b/%h want 10/%h", n, HTRANS, HADDR, rr_addr((n-1) % 2, (n-1) / 2));
                end
            end else begin
                checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rr_idle n=%0d: got %b want 00", n, HTRANS); end
            end
            if (n >= 3 && n <= 10) begin
                exp_rdy = ((n-3) % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (rsp_valid !== exp_rdy || rsp_err !== 1'b0 || rsp_rdata !== (rr_addr((n-3) % 2, (n-3) / 2) ^ Pat)) begin
                    errors++; $display("FAIL rr_rsp n=%0d: got %b/%b/%h want %b/0/%h", n, rsp_valid, rsp_err, rsp_rdata, exp_rdy, rr_addr((n-3) % 2, (n-3) / 2) ^ Pat);
                end
            end else begin
                checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rr_norsp n=%0d: got %b want 00", n, rsp_valid); end
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_single_write();
        @(negedge HCLK);
        set_req(0, 1'b1, 1'b1, 32'h10, 3'd2, 32'hA5A5A5A5); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sw_ready: got %b want 01", req_ready); end
        @(negedge HCLK);
        req_valid = 2'b00; #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h10 || HWRITE !== 1'b1 || HSIZE !== 3'd2) begin
            errors++; $display("FAIL sw_addr_phase: got %b/%h/%b/%0d want 10/10/1/2", HTRANS, HADDR, HWRITE, HSIZE);
        end
        checks++; if (HBURST !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL sw_burst_busy: got %b/%b want 000/1", HBURST, busy); end
        @(negedge HCLK); #1;
        checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'hA5A5A5A5 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL sw_data_phase: got %b/%h/%b want 00/a5a5a5a5/00", HTRANS, HWDATA, rsp_valid);
        end
        @(negedge HCLK); #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL sw_rsp: got %b/%b/%h want 01/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge HCLK); #1;
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL sw_done: got %b/%b want 00/0", rsp_valid, busy); end
    endtask

    task automatic test_wait_state();
        @(negedge HCLK);
        set_req(0, 1'b1, 1'b1, 32'h40, 3'd2, 32'h12345678); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ws_ready0: got %b want 01", req_ready); end
        @(negedge HCLK);
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h80, 3'd2, 32'h0); #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL ws_ready1: got %b want 10", req_ready); end
        @(negedge HCLK);
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h90, 3'd2, 32'h0);
        HREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
            if (w > 0) @(negedge HCLK);
            #1;
            checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h80 || HWDATA !== 32'h12345678 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
                errors++; $display("FAIL ws_hold w=%0d: got %b/%h/%h/%b/%b want 10/80/12345678/00/00", w, HTRANS, HADDR, HWDATA, req_ready, rsp_valid);
            end
        end
        @(negedge HCLK);
        HREADY = 1'b1; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ws_release: got %b want 01", req_ready); end
        @(negedge HCLK);
        req_valid = 2'b00; #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || HTRANS !== 2'b10 || HADDR !== 32'h90) begin
            errors++; $display("FAIL ws_complete: got %b/%b/%b/%h want 01/0/10/90", rsp_valid, rsp_err, HTRANS, HADDR);
        end
        @(negedge HCLK); #1;
        checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== (32'h80 ^ Pat)) begin
            errors++; $display("FAIL ws_rsp1: got %b/%h want 10/%h", rsp_valid, rsp_rdata, 32'h80 ^ Pat);
        end
        @(negedge HCLK); #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== (32'h90 ^ Pat)) begin
            errors++; $display("FAIL ws_rsp0: got %b/%h want 01/%h", rsp_valid, rsp_rdata, 32'h90 ^ Pat);
        end
        @(negedge HCLK); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ws_idle: got %b want 0", busy); end
    endtask

    task automatic test_error();
        @(negedge HCLK);
        set_req(0, 1'b1, 1'b0, 32'h300, 3'd2, 32'h0); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL err_ready0: got %b want 01", req_ready); end
        @(negedge HCLK);
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h400, 3'd2, 32'h0); #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL err_ready1: got %b want 10", req_ready); end
        @(negedge HCLK);
        req_valid = 2'b00; HRESP = 1'b1; HREADY = 1'b0; #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h400 || req_ready !== 2'b00) begin
            errors++; $display("FAIL err_cycle1: got %b/%h/%b want 10/400/00", HTRANS, HADDR, req_ready);
        end
        @(negedge HCLK);
        HREADY = 1'b1; #1;
        checks++; if (HTRANS !== 2'b00 || busy !== 1'b1 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL err_cycle2: got %b/%b/%b want 00/1/00", HTRANS, busy, rsp_valid);
        end
        @(negedge HCLK);
        HRESP = 1'b0; #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin errors++; $display("FAIL err_rsp: got %b/%b want 01/1", rsp_valid, rsp_err); end
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h400) begin errors++; $display("FAIL err_replay: got %b/%h want 10/400", HTRANS, HADDR); end
        @(negedge HCLK); #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL err_after: got %b/%b want 00/00", HTRANS, rsp_valid); end
        @(negedge HCLK); #1;
        checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== (32'h400 ^ Pat)) begin
            errors++; $display("FAIL err_rsp1: got %b/%b/%h want 10/0/%h", rsp_valid, rsp_err, rsp_rdata, 32'h400 ^ Pat);
        end
        @(negedge HCLK); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_idle: got %b want 0", busy); end
    endtask

    task automatic test_bad_size();
        @(negedge HCLK);
        set_req(0, 1'b1, 1'b0, 32'h500, 3'd3, 32'h0); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bs_ready: got %b want 01", req_ready); end
        @(negedge HCLK);
        req_valid = 2'b00; #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || HTRANS !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL bs_rsp: got %b/%b/%b/%b want 01/1/00/0", rsp_valid, rsp_err, HTRANS, busy);
        end
        @(negedge HCLK); #1;
        checks++; if (rsp_valid !== 2'b00 || HTRANS !== 2'b00) begin errors++; $display("FAIL bs_after: got %b/%b want 00/00", rsp_valid, HTRANS); end
    endtask

    task automatic test_reset_mid();
        @(negedge HCLK);
        set_req(1, 1'b1, 1'b1, 32'h600, 3'd2, 32'hDEADBEEF); #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rm_ready: got %b want 10", req_ready); end
        @(negedge HCLK);
        req_valid = 2'b00; #1;
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL rm_addr_phase: got %b want 10", HTRANS); end
        @(negedge HCLK);
        HRESET = 1'b1; #1;
        checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'h0 || HADDR !== 32'h0 || busy !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL rm_async: got %b/%h/%h/%b/%b want 00/0/0/0/00", HTRANS, HWDATA, HADDR, busy, rsp_valid);
        end
        @(negedge HCLK);
        HRESET = 1'b0; #1;
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL rm_release: got %b/%b/%b want 00/0/00", rsp_valid, busy, req_ready);
        end
        @(negedge HCLK); #1;
        checks++; if (rsp_valid !== 2'b00 || HTRANS !== 2'b00) begin errors++; $display("FAIL rm_dropped: got %b/%b want 00/00", rsp_valid, HTRANS); end
    endtask

    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_size = '0; req_wdata = '0;
        HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
        test_reset();
        test_rr_reads();
        test_single_write();
        test_wait_state();
        test_error();
        test_bad_size();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
